// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for a single data memory port (IDLE/ACCESS/RESP).
// Optional grant locking is compiled in with `define DBUS_ARB_LOCK_EN.
module dbus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_M0_Req,
    input  logic [ADDR_WIDTH-1:0] i_M0_Addr,
    input  logic                  i_M0_WrEnable,
    input  logic [DATA_WIDTH-1:0] i_M0_WrData,
    output logic                  o_M0_Ack,
    output logic [DATA_WIDTH-1:0] o_M0_RdData,
    input  logic                  i_M1_Req,
    input  logic [ADDR_WIDTH-1:0] i_M1_Addr,
    input  logic                  i_M1_WrEnable,
    input  logic [DATA_WIDTH-1:0] i_M1_WrData,
    output logic                  o_M1_Ack,
    output logic [DATA_WIDTH-1:0] o_M1_RdData,
`ifdef DBUS_ARB_LOCK_EN
    input  logic                  i_M0_Lock,
    input  logic                  i_M1_Lock,
`endif
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic                  o_Mem_WrEnable,
    output logic [DATA_WIDTH-1:0] o_Mem_WrData,
    input  logic [DATA_WIDTH-1:0] i_Mem_RdData,
    output logic                  o_Gnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("dbus_arbiter: LOCK_MAX must be at least 1");
    end

    state_t                state_q;
    logic                  sel_q;
    logic                  last_q;
    logic                  m0_ack_q;
    logic                  m1_ack_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  mem_we_q;

    logic                  gnt_d;
    logic                  nsel_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  we_d;
    logic                  stay_d;

`ifdef DBUS_ARB_LOCK_EN
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    logic [CNT_W-1:0] lock_cnt_q;
`endif

    always_comb begin
        // With both requesting, the master that did not win last time wins now.
        gnt_d   = (i_M0_Req && i_M1_Req) ? ~last_q : i_M1_Req;
        nsel_d  = (state_q == IDLE) ? gnt_d : sel_q;
        addr_d  = nsel_d ? i_M1_Addr     : i_M0_Addr;
        wdata_d = nsel_d ? i_M1_WrData   : i_M0_WrData;
        we_d    = nsel_d ? i_M1_WrEnable : i_M0_WrEnable;
`ifdef DBUS_ARB_LOCK_EN
        stay_d  = (sel_q ? (i_M1_Lock && i_M1_Req) : (i_M0_Lock && i_M0_Req))
                  && (int'(lock_cnt_q) < LOCK_MAX - 1);
`else
        stay_d  = 1'b0;
`endif
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
`ifdef DBUS_ARB_LOCK_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_M0_Req || i_M1_Req) begin
                        sel_q       <= gnt_d;
                        last_q      <= gnt_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        mem_we_q    <= we_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (!mem_we_q) begin
                        if (sel_q) m1_rdata_q <= i_Mem_RdData;
                        else       m0_rdata_q <= i_Mem_RdData;
                    end
                    if (sel_q) m1_ack_q <= 1'b1;
                    else       m0_ack_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    // A locked continuation reloads the port straight from the held master.
                    if (stay_d) begin
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        mem_we_q    <= we_d;
                        state_q     <= ACCESS;
`ifdef DBUS_ARB_LOCK_EN
                        lock_cnt_q  <= lock_cnt_q + 1'b1;
`endif
                    end else begin
                        state_q <= IDLE;
`ifdef DBUS_ARB_LOCK_EN
                        lock_cnt_q <= '0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_M0_Ack       = m0_ack_q;
    assign o_M1_Ack       = m1_ack_q;
    assign o_M0_RdData    = m0_rdata_q;
    assign o_M1_RdData    = m1_rdata_q;
    assign o_Mem_Addr     = mem_addr_q;
    assign o_Mem_WrData   = mem_wdata_q;
    assign o_Mem_WrEnable = mem_we_q;
    assign o_Gnt          = sel_q;

endmodule
